// File: rtl/axis_cpu_prog_loader_pkg.sv
// Shared definitions for the AXI-Stream program loader: section type codes
// and FSM state encodings.
package axis_cpu_prog_loader_pkg;

  localparam logic [7:0] LOADER_TYPE_INST = 8'h01;
  localparam logic [7:0] LOADER_TYPE_IMM  = 8'h02;
  localparam logic [7:0] LOADER_TYPE_JMP  = 8'h03;
  localparam logic [7:0] LOADER_TYPE_END  = 8'hFF;

  localparam logic [2:0] LOADER_ST_HDR    = 3'd0;
  localparam logic [2:0] LOADER_ST_INST_W = 3'd1;
  localparam logic [2:0] LOADER_ST_INST_E = 3'd2;
  localparam logic [2:0] LOADER_ST_TBL    = 3'd3;
  localparam logic [2:0] LOADER_ST_DRAIN  = 3'd4;

  localparam logic [16:0] LOADER_TBL_DEPTH = 17'd16;

  function automatic logic loader_is_tbl(input logic [7:0] t);
    return (t == LOADER_TYPE_IMM) || (t == LOADER_TYPE_JMP);
  endfunction

endpackage

// File: rtl/axis_cpu_prog_loader.sv
// Unpacks a sectioned program image from an AXI-Stream slave into the
// instruction memory, immediates table and jump-offset table write ports.
module axis_cpu_prog_loader
  import axis_cpu_prog_loader_pkg::*;
#(
  parameter int CODE_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [CODE_ADDR_WIDTH-1:0] inst_mem_wr_addr,
  output logic [7:0]                 inst_mem_wr_data,
  output logic                       inst_mem_wr_en,
  output logic [3:0]                 imm_wr_addr,
  output logic [31:0]                imm_wr_data,
  output logic                       imm_wr_en,
  output logic [3:0]                 jmp_off_wr_addr,
  output logic [7:0]                 jmp_off_wr_data,
  output logic                       jmp_off_wr_en,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam logic [16:0] INST_MAX = 17'd1 << CODE_ADDR_WIDTH;

  logic [2:0]                 state, state_n;
  logic [7:0]                 sec_type, sec_type_n;
  logic [16:0]                cnt, cnt_n;
  logic [4:0]                 idx, idx_n;
  logic [1:0]                 bidx, bidx_n;
  logic [31:0]                word, word_n;
  logic [CODE_ADDR_WIDTH-1:0] baddr, baddr_n;

  logic                       tready_n;
  logic [CODE_ADDR_WIDTH-1:0] inst_addr_n;
  logic [7:0]                 inst_data_n;
  logic                       inst_en_n;
  logic [3:0]                 imm_addr_n, jmp_addr_n;
  logic [31:0]                imm_data_n;
  logic [7:0]                 jmp_data_n;
  logic                       imm_en_n, jmp_en_n;
  logic                       busy_n, done_n, err_n;

  logic        hs;
  logic [7:0]  hdr_type;
  logic [16:0] hdr_cnt;
  logic        tbl_last;

  assign hs       = s_axis_tvalid & s_axis_tready;
  assign hdr_type = s_axis_tdata[31:24];
  assign hdr_cnt  = {1'b0, s_axis_tdata[15:0]};
  assign tbl_last = (17'(idx) + 17'd1) == cnt;

  always_comb begin
    state_n     = state;
    sec_type_n  = sec_type;
    cnt_n       = cnt;
    idx_n       = idx;
    bidx_n      = bidx;
    word_n      = word;
    baddr_n     = baddr;
    inst_addr_n = inst_mem_wr_addr;
    inst_data_n = inst_mem_wr_data;
    inst_en_n   = 1'b0;
    imm_addr_n  = imm_wr_addr;
    imm_data_n  = imm_wr_data;
    imm_en_n    = 1'b0;
    jmp_addr_n  = jmp_off_wr_addr;
    jmp_data_n  = jmp_off_wr_data;
    jmp_en_n    = 1'b0;
    busy_n      = busy;
    done_n      = 1'b0;
    err_n       = err;

    case (state)
      LOADER_ST_HDR: if (hs) begin
        sec_type_n = hdr_type;
        cnt_n      = hdr_cnt;
        idx_n      = '0;
        baddr_n    = '0;
        err_n      = 1'b0;
        busy_n     = 1'b1;
        if (hdr_type == LOADER_TYPE_END && s_axis_tlast) begin
          busy_n = 1'b0;
          done_n = 1'b1;
        end else if (s_axis_tlast) begin
          // Image ended on a non-END header: abandon without draining.
          err_n  = 1'b1;
          busy_n = 1'b0;
        end else if (hdr_type == LOADER_TYPE_INST) begin
          if (hdr_cnt > INST_MAX) begin
            err_n   = 1'b1;
            state_n = LOADER_ST_DRAIN;
          end else if (hdr_cnt != '0) begin
            state_n = LOADER_ST_INST_W;
          end
        end else if (loader_is_tbl(hdr_type)) begin
          if (hdr_cnt > LOADER_TBL_DEPTH) begin
            err_n   = 1'b1;
            state_n = LOADER_ST_DRAIN;
          end else if (hdr_cnt != '0) begin
            state_n = LOADER_ST_TBL;
          end
        end else begin
          err_n   = 1'b1;
          state_n = LOADER_ST_DRAIN;
        end
      end

      LOADER_ST_INST_W: if (hs) begin
        if (s_axis_tlast) begin
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = LOADER_ST_HDR;
        end else begin
          word_n  = s_axis_tdata;
          bidx_n  = '0;
          state_n = LOADER_ST_INST_E;
        end
      end

      LOADER_ST_INST_E: begin
        inst_en_n   = 1'b1;
        inst_addr_n = baddr;
        inst_data_n = word[{bidx, 3'b000} +: 8];
        baddr_n     = baddr + 1'b1;
        cnt_n       = cnt - 17'd1;
        bidx_n      = bidx + 2'd1;
        if (cnt == 17'd1)      state_n = LOADER_ST_HDR;
        else if (bidx == 2'd3) state_n = LOADER_ST_INST_W;
      end

      LOADER_ST_TBL: if (hs) begin
        if (s_axis_tlast) begin
          // The tlast word itself is dropped; earlier writes stand.
          err_n   = 1'b1;
          busy_n  = 1'b0;
          state_n = LOADER_ST_HDR;
        end else begin
          if (sec_type == LOADER_TYPE_IMM) begin
            imm_en_n   = 1'b1;
            imm_addr_n = idx[3:0];
            imm_data_n = s_axis_tdata;
          end else begin
            jmp_en_n   = 1'b1;
            jmp_addr_n = idx[3:0];
            jmp_data_n = s_axis_tdata[7:0];
          end
          idx_n = idx + 5'd1;
          if (tbl_last) state_n = LOADER_ST_HDR;
        end
      end

      LOADER_ST_DRAIN: if (hs && s_axis_tlast) begin
        busy_n  = 1'b0;
        state_n = LOADER_ST_HDR;
      end

      default: state_n = LOADER_ST_HDR;
    endcase

    tready_n = (state_n != LOADER_ST_INST_E);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= LOADER_ST_HDR;
      sec_type         <= '0;
      cnt              <= '0;
      idx              <= '0;
      bidx             <= '0;
      word             <= '0;
      baddr            <= '0;
      s_axis_tready    <= 1'b0;
      inst_mem_wr_addr <= '0;
      inst_mem_wr_data <= '0;
      inst_mem_wr_en   <= 1'b0;
      imm_wr_addr      <= '0;
      imm_wr_data      <= '0;
      imm_wr_en        <= 1'b0;
      jmp_off_wr_addr  <= '0;
      jmp_off_wr_data  <= '0;
      jmp_off_wr_en    <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      state            <= state_n;
      sec_type         <= sec_type_n;
      cnt              <= cnt_n;
      idx              <= idx_n;
      bidx             <= bidx_n;
      word             <= word_n;
      baddr            <= baddr_n;
      s_axis_tready    <= tready_n;
      inst_mem_wr_addr <= inst_addr_n;
      inst_mem_wr_data <= inst_data_n;
      inst_mem_wr_en   <= inst_en_n;
      imm_wr_addr      <= imm_addr_n;
      imm_wr_data      <= imm_data_n;
      imm_wr_en        <= imm_en_n;
      jmp_off_wr_addr  <= jmp_addr_n;
      jmp_off_wr_data  <= jmp_data_n;
      jmp_off_wr_en    <= jmp_en_n;
      busy             <= busy_n;
      done             <= done_n;
      err              <= err_n;
    end
  end

endmodule

// File: tb/tb_axis_cpu_prog_loader.sv
// Directed bench for axis_cpu_prog_loader: hand-computed write sequences,
// error handling, and asynchronous reset mid-load.
module tb_axis_cpu_prog_loader;

  localparam int CAW = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [31:0]    s_axis_tdata = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic           s_axis_tlast = 1'b0;
  logic [CAW-1:0] inst_mem_wr_addr;
  logic [7:0]     inst_mem_wr_data;
  logic           inst_mem_wr_en;
  logic [3:0]     imm_wr_addr;
  logic [31:0]    imm_wr_data;
  logic           imm_wr_en;
  logic [3:0]     jmp_off_wr_addr;
  logic [7:0]     jmp_off_wr_data;
  logic           jmp_off_wr_en;
  logic           busy, done, err;

  axis_cpu_prog_loader #(.CODE_ADDR_WIDTH(CAW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .inst_mem_wr_addr(inst_mem_wr_addr), .inst_mem_wr_data(inst_mem_wr_data),
    .inst_mem_wr_en(inst_mem_wr_en),
    .imm_wr_addr(imm_wr_addr), .imm_wr_data(imm_wr_data), .imm_wr_en(imm_wr_en),
    .jmp_off_wr_addr(jmp_off_wr_addr), .jmp_off_wr_data(jmp_off_wr_data),
    .jmp_off_wr_en(jmp_off_wr_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_wait = 0;
  int done_cnt = 0;
  logic busy_at_done = 1'b1;

  int inst_a[$], inst_d[$], inst_c[$];
  int imm_a[$], imm_c[$];
  logic [31:0] imm_d[$];
  int jmp_a[$], jmp_d[$];

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (inst_mem_wr_en) begin
      inst_a.push_back(int'(inst_mem_wr_addr));
      inst_d.push_back(int'(inst_mem_wr_data));
      inst_c.push_back(cyc);
    end
    if (imm_wr_en) begin
      imm_a.push_back(int'(imm_wr_addr));
      imm_d.push_back(imm_wr_data);
      imm_c.push_back(cyc);
    end
    if (jmp_off_wr_en) begin
      jmp_a.push_back(int'(jmp_off_wr_addr));
      jmp_d.push_back(int'(jmp_off_wr_data));
    end
    if (done) begin
      done_cnt++;
      busy_at_done = busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      failures++;
      $display("FAIL handshake_timeout: observed=no_tready required=tready");
    end
    @(posedge clk);
    #1;
    last_acc  = cyc;
    last_wait = n;
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int base, base_i, dn, acc, waits, exp_b;
    logic [31:0] w;

    // Reset state
    #2;
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_en", {inst_mem_wr_en, imm_wr_en, jmp_off_wr_en, done}, 0);
    chk("rst_addr", inst_mem_wr_addr, 0);
    #10 rst = 1'b1;
    @(posedge clk); #1;
    chk("tready_after_rst", s_axis_tready, 1);

    // INST N=6
    base = inst_a.size(); dn = done_cnt;
    send(32'h01000006, 0);
    chk("inst_busy", busy, 1);
    send(32'h44332211, 0);
    acc = last_acc;
    send(32'h00006655, 0);
    send(32'hFF000000, 1);
    idle(3);
    chk("inst6_count", inst_a.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      chk("inst6_addr", inst_a[base+i], i);
      chk("inst6_data", inst_d[base+i], 32'h11 * (i + 1));
    end
    chk("inst6_latency", inst_c[base] - acc, 2);
    chk("inst6_done", done_cnt - dn, 1);
    chk("inst6_busy_at_done", busy_at_done, 0);
    chk("inst6_busy_end", busy, 0);

    // IMM N=3 back-to-back
    base = imm_a.size(); waits = 0;
    send(32'h02000003, 0); waits += last_wait;
    send(32'h0000000A, 0); waits += last_wait; acc = last_acc;
    send(32'h0000000B, 0); waits += last_wait;
    send(32'hDEADBEEF, 0); waits += last_wait;
    send(32'hFF000000, 1); waits += last_wait;
    idle(2);
    chk("imm3_count", imm_a.size() - base, 3);
    chk("imm3_waits", waits, 0);
    chk("imm3_latency", imm_c[base] - acc, 1);
    chk("imm3_d0", imm_d[base], 32'hA);
    chk("imm3_d1", imm_d[base+1], 32'hB);
    chk("imm3_d2", imm_d[base+2], 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) chk("imm3_addr", imm_a[base+i], i);
    chk("imm3_consec", imm_c[base+2] - imm_c[base], 2);

    // JMP N=17: oversize, drain
    base = jmp_a.size();
    send(32'h03000011, 0);
    chk("jmp17_err", err, 1);
    send(32'h00000005, 0);
    send(32'h03000002, 0);
    chk("jmp17_drain_busy", busy, 1);
    send(32'h00000007, 1);
    idle(1);
    chk("jmp17_no_writes", jmp_a.size() - base, 0);
    chk("jmp17_busy_after", busy, 0);
    chk("jmp17_err_sticky", err, 1);
    send(32'h03000002, 0);
    chk("jmp_err_cleared", err, 0);
    send(32'h00000012, 0);
    send(32'h000001FF, 0);
    send(32'hFF000000, 1);
    idle(2);
    chk("jmp2_count", jmp_a.size() - base, 2);
    chk("jmp2_d1", jmp_d[base+1], 32'hFF);
    chk("jmp2_a1", jmp_a[base+1], 1);

    // Premature tlast on second IMM payload word
    base = imm_a.size();
    send(32'h02000003, 0);
    send(32'h00000111, 0);
    send(32'h00000222, 1);
    #2;
    chk("prem_err", err, 1);
    chk("prem_busy", busy, 0);
    send(32'h02000001, 0);
    chk("prem_next_hdr_wait", last_wait, 0);
    chk("prem_err_cleared", err, 0);
    send(32'h00000333, 0);
    send(32'hFF000000, 1);
    idle(2);
    chk("prem_count", imm_a.size() - base, 2);
    chk("prem_d0", imm_d[base], 32'h111);
    chk("prem_d1", imm_d[base+1], 32'h333);
    chk("prem_a1", imm_a[base+1], 0);

    // INST oversize (2^CAW + 1), then IMM N=0, then IMM N=16 boundary
    base_i = inst_a.size();
    send(32'h01000401, 0);
    chk("inst_over_err", err, 1);
    send(32'hFFFFFFFF, 1);
    idle(1);
    chk("inst_over_no_writes", inst_a.size() - base_i, 0);
    send(32'h02000000, 0);
    chk("imm0_err", err, 0);
    base = imm_a.size();
    send(32'h02000010, 0);
    for (int i = 0; i < 16; i++) send(32'h100 + i, 0);
    send(32'hFF000000, 1);
    idle(2);
    chk("imm16_count", imm_a.size() - base, 16);
    chk("imm16_last_addr", imm_a[base+15], 15);
    chk("imm16_last_data", imm_d[base+15], 32'h10F);
    chk("imm16_err", err, 0);

    // Async reset during third byte write of an INST word
    base = inst_a.size();
    send(32'h01000004, 0);
    send(32'hDDCCBBAA, 0);
    idle(0);
    for (int n = 0; n < 20 && inst_a.size() - base < 3; n++) begin
      @(negedge clk); #1;
    end
    chk("rst_mid_pre_en", inst_mem_wr_en, 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_en", inst_mem_wr_en, 0);
    chk("rst_mid_tready", s_axis_tready, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_no_more", inst_a.size() - base, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_tready_back", s_axis_tready, 1);
    base = inst_a.size(); dn = done_cnt;
    send(32'h01000003, 0);
    send(32'h00CCBBAA, 0);
    send(32'hFF000000, 1);
    idle(2);
    chk("fresh_count", inst_a.size() - base, 3);
    chk("fresh_d2", inst_d[base+2], 32'hCC);
    chk("fresh_a2", inst_a[base+2], 2);
    chk("fresh_done", done_cnt - dn, 1);

    // 64-byte INST with random tvalid gaps
    base = inst_a.size();
    send(32'h01000040, 0);
    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 4; b++) w[b*8 +: 8] = 8'((4*i + b) * 7 + 3);
      send(w, 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 4));
    end
    send(32'hFF000000, 1);
    idle(3);
    chk("inst64_count", inst_a.size() - base, 64);
    for (int i = 0; i < 64 && base + i < inst_a.size(); i++) begin
      exp_b = (i * 7 + 3) & 8'hFF;
      chk("inst64_addr", inst_a[base+i], i);
      chk("inst64_data", inst_d[base+i], exp_b);
    end
    chk("inst64_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
